phys_reg_free_list: RTL and testbench

- Circular free list of physical-register tags for the rename stage.
- Supplies the next free 6-bit tag to the allocation path. That tag drives the 6-to-64 one-hot decoder, which sets busy/valid bits.
- Accepts tags released at retirement.
- Keeps a committed head pointer so a pipeline flush reclaims all speculatively allocated tags in one cycle.

---
 rtl/rename_pkg.sv | 10 +
 rtl/phys_reg_free_list_if.sv | 25 ++
 rtl/phys_reg_free_list_ring_ptr.sv | 31 +++
 rtl/phys_reg_free_list.sv | 67 ++++++
 tb/tb_phys_reg_free_list.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/rename_pkg.sv
// Shared rename-stage constants and tag/pointer types.
package rename_pkg;
    localparam int NUM_PREGS = 64;
    localparam int NUM_ARCH  = 32;
    localparam int TAG_W     = 6;
    localparam int PTR_W     = TAG_W + 1;

    typedef logic [TAG_W-1:0] preg_tag_t;
    typedef logic [PTR_W-1:0] fl_ptr_t;
endpackage

// File: rtl/phys_reg_free_list_if.sv
// Allocation / release / commit port bundle of the physical-register free list.
interface phys_reg_free_list_if;
    import rename_pkg::*;

    logic      alloc_req;
    logic      alloc_valid;
    preg_tag_t alloc_tag;
    logic      free_valid;
    preg_tag_t free_tag;
    logic      retire_valid;
    logic      flush;
    fl_ptr_t   count;
    logic      err_overflow;
    logic      err_underflow;

    modport master (
        output alloc_req, free_valid, free_tag, retire_valid, flush,
        input  alloc_valid, alloc_tag, count, err_overflow, err_underflow
    );

    modport slave (
        input  alloc_req, free_valid, free_tag, retire_valid, flush,
        output alloc_valid, alloc_tag, count, err_overflow, err_underflow
    );
endinterface

// File: rtl/phys_reg_free_list_ring_ptr.sv
// Wrap-bit ring pointer: increments modulo 2^W, load has priority over increment.
// Latency: new value visible the cycle after inc/ld.
// Backpressure: none; caller gates inc.
module ring_ptr #(
    parameter int           W       = 7,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    output logic [W-1:0] ptr_q
);
    logic [W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (ld)
            ptr_d = ld_val;
        else if (inc)
            ptr_d = ptr_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr_q <= RST_VAL;
        else
            ptr_q <= ptr_d;
    end
endmodule

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical-register tags with a committed head for one-cycle flush recovery.
// Latency: alloc_tag/alloc_valid/count are combinational from state; a freed tag is allocatable next cycle.
// Backpressure: alloc_valid low when empty or flushing; pushes into a full list are dropped and flagged.
module phys_reg_free_list
    import rename_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    phys_reg_free_list_if.slave io
);
    preg_tag_t entry_q [NUM_PREGS];
    preg_tag_t entry_d [NUM_PREGS];
    fl_ptr_t   head_q, tail_q, chead_q, chead_tgt, count;
    logic      empty, full, alloc_vld, pop, push, retire_ok;
    logic      err_overflow_q, err_overflow_d;
    logic      err_underflow_q, err_underflow_d;

    assign count     = tail_q - head_q;
    assign empty     = (count == '0);
    assign full      = (count == PTR_W'(NUM_PREGS));
    assign alloc_vld = !empty && !io.flush;
    assign pop       = io.alloc_req && alloc_vld;
    // A pop in the same cycle frees a slot, so a push at full still succeeds.
    assign push      = io.free_valid && (!full || pop);
    assign retire_ok = io.retire_valid && (chead_q != head_q);
    // Flush rewinds to the committed head including any retire in the same cycle.
    assign chead_tgt = retire_ok ? chead_q + PTR_W'(1) : chead_q;

    assign io.alloc_valid   = alloc_vld;
    assign io.alloc_tag     = entry_q[head_q[TAG_W-1:0]];
    assign io.count         = count;
    assign io.err_overflow  = err_overflow_q;
    assign io.err_underflow = err_underflow_q;

    ring_ptr #(.W(PTR_W), .RST_VAL('0)) u_head (
        .clk(clk), .rst_n(rst_n), .inc(pop), .ld(io.flush), .ld_val(chead_tgt), .ptr_q(head_q)
    );

    ring_ptr #(.W(PTR_W), .RST_VAL(PTR_W'(NUM_PREGS - NUM_ARCH))) u_tail (
        .clk(clk), .rst_n(rst_n), .inc(push), .ld(1'b0), .ld_val('0), .ptr_q(tail_q)
    );

    ring_ptr #(.W(PTR_W), .RST_VAL('0)) u_chead (
        .clk(clk), .rst_n(rst_n), .inc(retire_ok), .ld(1'b0), .ld_val('0), .ptr_q(chead_q)
    );

    always_comb begin
        entry_d = entry_q;
        if (push)
            entry_d[tail_q[TAG_W-1:0]] = io.free_tag;
        err_overflow_d  = err_overflow_q  | (io.free_valid && !push);
        err_underflow_d = err_underflow_q | (io.retire_valid && !retire_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PREGS; i++)
                entry_q[i] <= (i < NUM_PREGS - NUM_ARCH) ? TAG_W'(NUM_ARCH + i) : '0;
            err_overflow_q  <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            entry_q         <= entry_d;
            err_overflow_q  <= err_overflow_d;
            err_underflow_q <= err_underflow_d;
        end
    end
endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed + randomized bench for phys_reg_free_list against a queue-based free-list model.
module tb_phys_reg_free_list;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    phys_reg_free_list_if io ();

    phys_reg_free_list dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    always #5 clk = ~clk;

    // Model: freeq holds allocatable tags oldest-first; specq holds allocated-but-uncommitted tags.
    logic [5:0] freeq [$];
    logic [5:0] specq [$];
    bit         m_ovf, m_unf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        freeq.delete();
        specq.delete();
        for (int i = 0; i < 32; i++) freeq.push_back(6'(32 + i));
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic idle();
        io.alloc_req    = 1'b0;
        io.free_valid   = 1'b0;
        io.free_tag     = '0;
        io.retire_valid = 1'b0;
        io.flush        = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // One clock cycle: drive, check outputs against the model, apply the edge, update the model.
    task automatic step(input bit req, input bit fv, input logic [5:0] tag, input bit ret, input bit fl);
        bit         exp_vld, pop_ok, push_ok;
        logic [5:0] t;
        io.alloc_req    = req;
        io.free_valid   = fv;
        io.free_tag     = tag;
        io.retire_valid = ret;
        io.flush        = fl;
        #1;
        exp_vld = (freeq.size() > 0) && !fl;
        chk("alloc_valid", io.alloc_valid, exp_vld);
        chk("count", io.count, freeq.size());
        if (exp_vld) chk("alloc_tag", io.alloc_tag, freeq[0]);
        chk("err_overflow", io.err_overflow, m_ovf);
        chk("err_underflow", io.err_underflow, m_unf);
        @(posedge clk);
        pop_ok  = req && exp_vld;
        push_ok = fv && (freeq.size() < 64 || pop_ok);
        if (fv && !push_ok) m_ovf = 1'b1;
        if (ret) begin
            if (specq.size() > 0) t = specq.pop_front();
            else m_unf = 1'b1;
        end
        if (pop_ok) begin
            t = freeq.pop_front();
            specq.push_back(t);
        end
        if (fl) begin
            freeq = {specq, freeq};
            specq.delete();
        end
        if (push_ok) freeq.push_back(tag);
        @(negedge clk);
        idle();
    endtask

    initial begin
        bit         r_req, r_fv, r_ret, r_fl;
        logic [5:0] r_tag;
        idle();
        model_reset();
        #12;
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        chk("rst_count", io.count, 32);
        chk("rst_valid", io.alloc_valid, 1);
        chk("rst_tag", io.alloc_tag, 32);
        chk("rst_ovf", io.err_overflow, 0);
        chk("rst_unf", io.err_underflow, 0);

        // Drain in order
        for (int i = 0; i < 32; i++) begin
            chk("drain_tag", io.alloc_tag, 32 + i);
            step(1, 0, 0, 0, 0);
        end
        chk("empty_valid", io.alloc_valid, 0);
        chk("empty_count", io.count, 0);
        step(1, 0, 0, 0, 0);
        chk("empty_alloc_count", io.count, 0);

        // Free then reuse; alloc+free at empty has no bypass
        step(0, 1, 6'd5, 0, 0);
        chk("reuse_valid", io.alloc_valid, 1);
        chk("reuse_tag", io.alloc_tag, 5);
        chk("reuse_count", io.count, 1);
        step(1, 0, 0, 0, 0);
        step(1, 1, 6'd7, 0, 0);
        chk("nobypass_count", io.count, 1);
        chk("nobypass_tag", io.alloc_tag, 7);

        // Flush recovery
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        chk("flush_tag", io.alloc_tag, 35);
        chk("flush_count", io.count, 29);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1);
        chk("flush_ret_tag", io.alloc_tag, 36);
        chk("flush_ret_count", io.count, 28);

        // Underflow: retire with nothing outstanding holds chead
        do_reset();
        step(0, 0, 0, 1, 0);
        chk("unf_flag", io.err_underflow, 1);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("unf_chead_held", io.alloc_tag, 32);

        // Fill, alloc+free at full, overflow drop, then drain checking FIFO order
        do_reset();
        for (int i = 0; i < 32; i++) step(0, 1, 6'(i), 0, 0);
        chk("full_count", io.count, 64);
        step(1, 1, 6'd50, 0, 0);
        chk("full_swap_count", io.count, 64);
        chk("full_swap_ovf", io.err_overflow, 0);
        step(0, 1, 6'd9, 0, 0);
        chk("ovf_flag", io.err_overflow, 1);
        chk("ovf_count", io.count, 64);
        chk("ovf_head_intact", io.alloc_tag, 33);
        for (int i = 0; i < 64; i++) step(1, 0, 0, 0, 0);
        chk("ovf_drained", io.alloc_valid, 0);

        // Randomized traffic across the pointer wrap
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r_req = ($urandom_range(0, 3) != 0);
            r_ret = (specq.size() > 0) && ($urandom_range(0, 3) != 0);
            r_fv  = ($urandom_range(0, 1) == 1) && (freeq.size() + specq.size() < 64);
            r_fl  = ($urandom_range(0, 15) == 0);
            r_tag = 6'($urandom_range(0, 63));
            step(r_req, r_fv, r_tag, r_ret, r_fl);
        end

        // Mid-operation asynchronous reset with sticky flag set beforehand
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0);
        chk("pre_rst_unf", io.err_underflow, 1);
        io.alloc_req  = 1'b1;
        io.free_valid = 1'b1;
        io.free_tag   = 6'd3;
        io.flush      = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", io.count, 32);
        chk("arst_tag", io.alloc_tag, 32);
        chk("arst_ovf", io.err_overflow, 0);
        chk("arst_unf", io.err_underflow, 0);
        chk("arst_valid_flush", io.alloc_valid, 0);
        idle();
        #1;
        chk("arst_valid", io.alloc_valid, 1);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(1, 0, 0, 0, 0);
        chk("post_rst_tag", io.alloc_tag, 33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
